// File: rtl/instr_prefetch_unit.sv
// ============================================================================
// Module   : instr_prefetch_unit
// Brief    : Sequential instruction prefetcher feeding the RV32I core. Issues
//            word fetches under a credit limit, buffers returned words in an
//            in-order FIFO and flushes/restarts on a redirect.
// Config   : IFU_BYPASS_EN - when defined, a word returning into an empty FIFO
//            is presented to the core in the same cycle (combinational path).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic                   ImemReq,
    output logic [PC_WIDTH-1:0]    ImemAddr,
    input  logic                   ImemGnt,
    input  logic                   ImemRvalid,
    input  logic [INSTR_WIDTH-1:0] ImemRdata,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    RedirectPc,
    output logic                   InstrValid,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    InstrPc,
    input  logic                   InstrReady
);

    localparam int                  c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                  c_CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0]    c_DEPTH      = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PC_WIDTH-1:0] c_WORD_STEP  = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = ~PC_WIDTH'(3);

    // Buffer storage and bookkeeping
    logic [INSTR_WIDTH-1:0] r_fifoMem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wrPtr;
    logic [c_PTR_W-1:0]     r_rdPtr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     r_outstanding;
    logic [c_CNT_W-1:0]     r_discard;
    logic [PC_WIDTH-1:0]    r_fetchPc;
    logic [PC_WIDTH-1:0]    r_outPc;

    logic                   w_fifoEmpty;
    logic [c_CNT_W:0]       w_inUse;
    logic                   w_credit;
    logic                   w_grant;
    logic                   w_rsp;
    logic                   w_drop;
    logic                   w_accept;
    logic                   w_bypass;
    logic                   w_pop;
    logic                   w_popFifo;
    logic                   w_push;
    logic [PC_WIDTH-1:0]    w_redirPc;

    assign w_fifoEmpty = (r_count == '0);

    // Every buffered word plus every in-flight request owns one FIFO slot,
    // so a returning word always has somewhere to land.
    assign w_inUse  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit = (w_inUse < c_DEPTH);

    // Reset gates the request so it drops the instant reset is asserted.
    assign ImemReq  = w_credit & ~Redirect & Reset;
    assign ImemAddr = r_fetchPc;
    assign w_grant  = ImemReq & ImemGnt;

    // A response with nothing outstanding is a protocol violation; ignore it.
    assign w_rsp    = ImemRvalid & (r_outstanding != '0);
    assign w_drop   = w_rsp & (r_discard != '0);
    assign w_accept = w_rsp & ~w_drop;

`ifdef IFU_BYPASS_EN
    assign w_bypass   = w_fifoEmpty & w_accept;
    assign InstrValid = ~w_fifoEmpty | w_bypass;
    assign Instr      = w_bypass    ? ImemRdata :
                        w_fifoEmpty ? '0        : r_fifoMem[r_rdPtr];
`else
    assign w_bypass   = 1'b0;
    assign InstrValid = ~w_fifoEmpty;
    assign Instr      = w_fifoEmpty ? '0 : r_fifoMem[r_rdPtr];
`endif

    assign InstrPc = r_outPc;

    // A bypassed word that the core takes immediately never enters the FIFO.
    assign w_pop     = InstrValid & InstrReady;
    assign w_popFifo = w_pop & ~w_fifoEmpty;
    assign w_push    = w_accept & ~(w_bypass & InstrReady);

    assign w_redirPc = RedirectPc & c_ALIGN_MASK;

    // Control state: pointers, occupancy, credits, discard count and PCs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fetchPc     <= RESET_PC;
            r_outPc       <= RESET_PC;
        end else if (Redirect) begin
            // Everything still in flight after this cycle belongs to the old
            // path; a response landing now is already accounted for.
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - c_CNT_W'(w_rsp);
            r_discard     <= r_outstanding - c_CNT_W'(w_rsp);
            r_fetchPc     <= w_redirPc;
            r_outPc       <= w_redirPc;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_popFifo) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_popFifo);
            r_outstanding <= r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);
            r_discard     <= r_discard - c_CNT_W'(w_drop);
            if (w_grant) begin
                r_fetchPc <= r_fetchPc + c_WORD_STEP;
            end
            if (w_pop) begin
                r_outPc <= r_outPc + c_WORD_STEP;
            end
        end
    end

    // FIFO data array; contents are don't-care until covered by r_count
    always_ff @(posedge Clk) begin
        if (w_push && !Redirect) begin
            r_fifoMem[r_wrPtr] <= ImemRdata;
        end
    end

    // Responses are only legal while at least one request is outstanding
    a_noOrphanRsp: assert property (@(posedge Clk) disable iff (!Reset)
                                    ImemRvalid |-> (r_outstanding != '0));

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
// Module   : tb_instr_prefetch_unit
// Brief    : Scoreboard bench for instr_prefetch_unit with an in-order
//            instruction memory model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic        InstrReady;

    // Second instance only used to observe a non-zero reset PC
    logic        ImemReq2;
    logic [31:0] ImemAddr2;
    logic        InstrValid2;
    logic [31:0] Instr2;
    logic [31:0] InstrPc2;

    instr_prefetch_unit #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)
    ) u_dut (
        .Clk(Clk), .Reset(Reset),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
        .Redirect(Redirect), .RedirectPc(RedirectPc),
        .InstrValid(InstrValid), .Instr(Instr), .InstrPc(InstrPc),
        .InstrReady(InstrReady)
    );

    instr_prefetch_unit #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
    ) u_dut2 (
        .Clk(Clk), .Reset(Reset),
        .ImemReq(ImemReq2), .ImemAddr(ImemAddr2), .ImemGnt(1'b0),
        .ImemRvalid(1'b0), .ImemRdata(32'h0),
        .Redirect(1'b0), .RedirectPc(32'h0),
        .InstrValid(InstrValid2), .Instr(Instr2), .InstrPc(InstrPc2),
        .InstrReady(1'b0)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] expQ[$];
    logic [31:0] memQ[$];

    // Stimulus knobs applied at each falling edge
    logic        rstVal     = 1'b0;
    logic        redirVal   = 1'b0;
    logic [31:0] redirPcVal = 32'h0;
    logic        gntEn      = 1'b1;
    logic        rspHold    = 1'b0;
    logic        readyEn    = 1'b0;
    logic        readyForce = 1'b0;

    int stepNo   = 0;
    int grants   = 0;
    int firstPop = -1;
    int lastPop  = -1;
    int relStep  = 0;
    int expLat;
    logic [31:0] monExp;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_5000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, then record any grant
    task automatic step();
        @(negedge Clk);
        stepNo++;
        Reset      = rstVal;
        Redirect   = redirVal;
        RedirectPc = redirPcVal;
        ImemGnt    = gntEn;
        if (!Reset) begin
            memQ.delete();
            ImemRvalid = 1'b0;
            ImemRdata  = 32'hDEAD_BEEF;
        end else if (!rspHold && memQ.size() > 0) begin
            ImemRvalid = 1'b1;
            ImemRdata  = memWord(memQ.pop_front());
        end else begin
            ImemRvalid = 1'b0;
            ImemRdata  = 32'hDEAD_BEEF;
        end
        InstrReady = readyEn && (expQ.size() > 0 || readyForce);
        #1;
        if (Reset && ImemReq && ImemGnt) begin
            memQ.push_back(ImemAddr);
            grants++;
        end
        #2;
    endtask

    task automatic waitEmpty(input string name);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 60) begin
            step();
            n++;
        end
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Scoreboard monitor: every accepted instruction outside a redirect
    // cycle must match the next expected PC and its memory word.
    always @(negedge Clk) begin
        #2;
        if (Reset && InstrValid && InstrReady && !Redirect) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h want none", InstrPc, Instr);
            end else begin
                monExp = expQ.pop_front();
                if (InstrPc !== monExp || Instr !== memWord(monExp)) begin
                    bad++;
                    $display("FAIL sb_pop: got pc=%h instr=%h want pc=%h instr=%h",
                             InstrPc, Instr, monExp, memWord(monExp));
                end
            end
            if (firstPop < 0) firstPop = stepNo;
            lastPop = stepNo;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Redirect = 1'b0; RedirectPc = '0; ImemGnt = 1'b1;
        ImemRvalid = 1'b0; ImemRdata = '0; InstrReady = 1'b0;
`ifdef IFU_BYPASS_EN
        expLat = 1;
`else
        expLat = 2;
`endif

        // ---- Reset values ----
        rstVal = 1'b0;
        repeat (3) step();
        chk("rst_req",    {31'b0, ImemReq},    32'h0);
        chk("rst_addr",   ImemAddr,            32'h0);
        chk("rst_valid",  {31'b0, InstrValid}, 32'h0);
        chk("rst_instr",  Instr,               32'h0);
        chk("rst_pc",     InstrPc,             32'h0);
        chk("rst2_req",   {31'b0, ImemReq2},   32'h0);
        chk("rst2_addr",  ImemAddr2,           32'hFFFF_FFF8);
        chk("rst2_pc",    InstrPc2,            32'hFFFF_FFF8);

        // ---- Zero-wait streaming ----
        for (int i = 0; i < 8; i++) expQ.push_back(32'(i * 4));
        readyEn = 1'b1; gntEn = 1'b1; rspHold = 1'b0; rstVal = 1'b1;
        firstPop = -1;
        step();
        relStep = stepNo;
        step();
        chk("rvalid_cycle_valid", {31'b0, InstrValid}, (expLat == 1) ? 32'h1 : 32'h0);
        waitEmpty("stream");
        chk("fill_latency", 32'(firstPop - relStep), 32'(expLat));
        chk("stream_gapless", 32'(lastPop - firstPop), 32'd7);

        // ---- Core stalls for 10 cycles ----
        rstVal = 1'b0; step();
        readyEn = 1'b0; rstVal = 1'b1; grants = 0;
        repeat (10) step();
        chk("stall_grants", 32'(grants), 32'd4);
        chk("stall_req",    {31'b0, ImemReq},    32'h0);
        chk("stall_valid",  {31'b0, InstrValid}, 32'h1);
        chk("stall_pc",     InstrPc,             32'h0);
        chk("stall_instr",  Instr,               memWord(32'h0));
        for (int i = 0; i < 10; i++) expQ.push_back(32'(i * 4));
        readyEn = 1'b1;
        waitEmpty("stall_resume");

        // ---- Redirect with two responses in flight ----
        rstVal = 1'b0; step();
        rstVal = 1'b1; readyEn = 1'b0; rspHold = 1'b1; gntEn = 1'b1;
        step(); step();
        gntEn = 1'b0; redirVal = 1'b1; redirPcVal = 32'h0000_0103;
        step();
        chk("redir_req_low", {31'b0, ImemReq}, 32'h0);
        redirVal = 1'b0; gntEn = 1'b1; rspHold = 1'b0; readyEn = 1'b1;
        expQ.push_back(32'h100); expQ.push_back(32'h104); expQ.push_back(32'h108);
        step();
        chk("redir_addr", ImemAddr,            32'h100);
        chk("redir_req",  {31'b0, ImemReq},    32'h1);
        waitEmpty("redir_inflight");

        // ---- Redirect colliding with a pop and a response ----
        rstVal = 1'b0; step();
        expQ.push_back(32'h0);
        rstVal = 1'b1; readyEn = 1'b1; rspHold = 1'b0; gntEn = 1'b1;
        step(); step(); step();
        redirVal = 1'b1; redirPcVal = 32'h0000_0200; readyForce = 1'b1;
        step();
        chk("collide_valid",  {31'b0, InstrValid}, 32'h1);
        chk("collide_rvalid_seen", {31'b0, ImemRvalid & InstrReady}, 32'h1);
        redirVal = 1'b0; readyForce = 1'b0;
        expQ.push_back(32'h200); expQ.push_back(32'h204); expQ.push_back(32'h208);
        waitEmpty("redir_collide");

        // ---- Back-to-back redirects, wrap at the top of the address space ----
        rspHold = 1'b1; readyEn = 1'b0;
        step(); step();
        redirVal = 1'b1; redirPcVal = 32'h0000_0300;
        step();
        rspHold = 1'b0; redirPcVal = 32'hFFFF_FFFA;
        step();
        redirVal = 1'b0; readyEn = 1'b1;
        expQ.push_back(32'hFFFF_FFF8); expQ.push_back(32'hFFFF_FFFC);
        expQ.push_back(32'h0000_0000); expQ.push_back(32'h0000_0004);
        waitEmpty("wrap");

        // ---- Reset mid-stream with three outstanding ----
        rstVal = 1'b0; step();
        readyEn = 1'b0; rspHold = 1'b0; gntEn = 1'b1; rstVal = 1'b1;
        step(); step();
        rspHold = 1'b1;
        step(); step();
        chk("pre_rst_valid", {31'b0, InstrValid}, 32'h1);
        rstVal = 1'b0;
        step();
        chk("mid_rst_req",   {31'b0, ImemReq},    32'h0);
        chk("mid_rst_addr",  ImemAddr,            32'h0);
        chk("mid_rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("mid_rst_instr", Instr,               32'h0);
        chk("mid_rst_pc",    InstrPc,             32'h0);
        rspHold = 1'b0; rstVal = 1'b1; readyEn = 1'b1;
        expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8);
        step();
        waitEmpty("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
